// File: rtl/kbd_matrix_mapper_if.sv
// Bus bundle for kbd_matrix_mapper: key events, column select, row readback,
// map ROM port and status.
interface kbd_matrix_mapper_if #(
  parameter int ROWS = 8,
  parameter int COLS = 8
);
  localparam int RW = $clog2(ROWS);
  localparam int CW = $clog2(COLS);

  logic [10:0]       ps2_key;
  logic [COLS-1:0]   addr;
  logic [ROWS-1:0]   kb_rows;
  logic [8:0]        map_addr;
  logic [RW+CW+2:0]  map_data;
  logic [11:1]       Fn;
  logic [2:0]        modif;
  logic              fifo_ovf;
  logic              busy;

  // Host side: key source, CPU column scan and the map ROM.
  modport master (
    output ps2_key, addr, map_data,
    input  kb_rows, map_addr, Fn, modif, fifo_ovf, busy
  );

  // Converter side.
  modport slave (
    input  ps2_key, addr, map_data,
    output kb_rows, map_addr, Fn, modif, fifo_ovf, busy
  );
endinterface

// File: rtl/kbd_matrix_mapper.sv
// PS/2 event to active-low key matrix converter with event FIFO, external
// map ROM lookup, shift forcing and a minimum hold time per applied event.
//
// state  | meaning
// IDLE   | waiting for a queued event; pops and issues the ROM address
// LOOKUP | one cycle for the map ROM to answer
// APPLY  | map_data valid: update Fn/modif, matrix and force state
// HOLD   | keep the new matrix stable for HOLD_CYCLES before the next event
module kbd_matrix_mapper #(
  parameter int ROWS        = 8,
  parameter int COLS        = 8,
  parameter int FIFO_DEPTH  = 8,
  parameter int HOLD_CYCLES = 4096,
  parameter int SHIFT_ROW   = 6,
  parameter int SHIFT_COL   = 7
) (
  input  logic clk_sys,
  input  logic reset,
  kbd_matrix_mapper_if.slave bus
);
  localparam int RW = $clog2(ROWS);
  localparam int CW = $clog2(COLS);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HW-1:0] HOLD_LOAD = HW'((HOLD_CYCLES > 0) ? HOLD_CYCLES - 1 : 0);

  typedef enum logic [1:0] {IDLE, LOOKUP, APPLY, HOLD} state_t;

  state_t state, next_state;
  logic   pop, apply_en, hold_load;

  // event = {pressed, extended, code}
  logic                     old_toggle;
  logic                     cap_valid;
  logic [9:0]               cap_event;
  logic [9:0]               mem [FIFO_DEPTH];
  logic [AW:0]              wr_ptr, rd_ptr;
  logic                     empty, full, push;
  logic                     ovf_q;

  logic [8:0]               map_addr_q;
  logic                     cur_pressed;
  logic [HW-1:0]            hold_cnt;

  logic [ROWS-1:0][COLS-1:0] mat, eff;
  logic                     force_on, force_off;
  logic [RW-1:0]            force_row;
  logic [CW-1:0]            force_col;
  logic [11:1]              fn_q;
  logic [2:0]               modif_q;
  logic [ROWS-1:0]          rows_n;

  logic                     md_valid;
  logic [RW-1:0]            md_row;
  logic [CW-1:0]            md_col;
  logic [1:0]               md_force;
  logic                     in_range;

  assign md_valid = bus.map_data[RW+CW+2];
  assign md_row   = bus.map_data[RW+CW+1 -: RW];
  assign md_col   = bus.map_data[CW+1 -: CW];
  assign md_force = bus.map_data[1:0];
  // Out-of-range coordinates are handled exactly like an unmapped key.
  assign in_range = md_valid && ({1'b0, md_row} < ROWS[RW:0]) && ({1'b0, md_col} < COLS[CW:0]);

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign push  = cap_valid && !full;

  // Detect a toggle of ps2_key[10] and hold the event for one cycle before queuing.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      old_toggle <= 1'b0;
      cap_valid  <= 1'b0;
      cap_event  <= '0;
    end else begin
      old_toggle <= bus.ps2_key[10];
      cap_valid  <= (bus.ps2_key[10] != old_toggle);
      cap_event  <= bus.ps2_key[9:0];
    end
  end

  // FIFO pointers and sticky overflow; a full FIFO drops the push even when popping.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      ovf_q  <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (cap_valid && full) ovf_q <= 1'b1;
    end
  end

  // FIFO storage; contents are don't-care while the pointers say empty.
  always_ff @(posedge clk_sys) begin
    if (push) mem[wr_ptr[AW-1:0]] <= cap_event;
  end

  // FSM state register.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // FSM next-state and control strobes.
  always_comb begin
    next_state = state;
    pop        = 1'b0;
    apply_en   = 1'b0;
    hold_load  = 1'b0;
    case (state)
      IDLE: begin
        if (!empty) begin
          pop        = 1'b1;
          next_state = LOOKUP;
        end
      end
      LOOKUP: next_state = APPLY;
      APPLY: begin
        apply_en = 1'b1;
        if (in_range && (HOLD_CYCLES > 0)) begin
          hold_load  = 1'b1;
          next_state = HOLD;
        end else begin
          next_state = IDLE;
        end
      end
      HOLD: begin
        if (hold_cnt == '0) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Hold timer: down-counter, terminal count zero ends HOLD.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset)                                hold_cnt <= '0;
    else if (hold_load)                       hold_cnt <= HOLD_LOAD;
    else if (state == HOLD && hold_cnt != '0) hold_cnt <= hold_cnt - 1'b1;
  end

  // Latch the popped event: ROM address and press/release flag.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      map_addr_q  <= '0;
      cur_pressed <= 1'b0;
    end else if (pop) begin
      map_addr_q  <= mem[rd_ptr[AW-1:0]][8:0];
      cur_pressed <= mem[rd_ptr[AW-1:0]][9];
    end
  end

  // Function keys and modifiers follow the non-extended code whether mapped or not.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      fn_q    <= '0;
      modif_q <= '0;
    end else if (apply_en && !map_addr_q[8]) begin
      case (map_addr_q[7:0])
        8'h05:   fn_q[1]    <= cur_pressed;
        8'h06:   fn_q[2]    <= cur_pressed;
        8'h04:   fn_q[3]    <= cur_pressed;
        8'h0C:   fn_q[4]    <= cur_pressed;
        8'h03:   fn_q[5]    <= cur_pressed;
        8'h0B:   fn_q[6]    <= cur_pressed;
        8'h83:   fn_q[7]    <= cur_pressed;
        8'h0A:   fn_q[8]    <= cur_pressed;
        8'h01:   fn_q[9]    <= cur_pressed;
        8'h09:   fn_q[10]   <= cur_pressed;
        8'h78:   fn_q[11]   <= cur_pressed;
        8'h14:   modif_q[2] <= cur_pressed;
        8'h11:   modif_q[1] <= cur_pressed;
        8'h59:   modif_q[0] <= cur_pressed;
        default: ;
      endcase
    end
  end

  // Matrix cell update and shift-force tracking for mapped, in-range keys.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      mat       <= '1;
      force_on  <= 1'b0;
      force_off <= 1'b0;
      force_row <= '0;
      force_col <= '0;
    end else if (apply_en && in_range) begin
      mat[md_row][md_col] <= ~cur_pressed;
      if (cur_pressed && md_force == 2'b01) begin
        force_on  <= 1'b1;
        force_off <= 1'b0;
        force_row <= md_row;
        force_col <= md_col;
      end else if (cur_pressed && md_force == 2'b10) begin
        force_on  <= 1'b0;
        force_off <= 1'b1;
        force_row <= md_row;
        force_col <= md_col;
      end else if (!cur_pressed && md_row == force_row && md_col == force_col) begin
        force_on  <= 1'b0;
        force_off <= 1'b0;
      end
    end
  end

  // Combinational readout: shift override, then wired-AND over selected columns.
  always_comb begin
    eff = mat;
    if (force_on)       eff[SHIFT_ROW][SHIFT_COL] = 1'b0;
    else if (force_off) eff[SHIFT_ROW][SHIFT_COL] = 1'b1;
    rows_n = '1;
    for (int r = 0; r < ROWS; r++) begin
      rows_n[r] = ~|(~eff[r] & ~bus.addr);
    end
  end

  assign bus.kb_rows  = rows_n;
  assign bus.map_addr = map_addr_q;
  assign bus.Fn       = fn_q;
  assign bus.modif    = modif_q;
  assign bus.fifo_ovf = ovf_q;
  assign bus.busy     = (state != IDLE) || !empty;
endmodule

// File: tb/tb_kbd_matrix_mapper.sv
// Bench for kbd_matrix_mapper: directed scenarios plus random event traffic,
// checked every cycle against a timeline model of the converter.
module tb_kbd_matrix_mapper;
  localparam int ROWS = 7;   // non-power-of-two so row 7 is out of range
  localparam int COLS = 8;
  localparam int DEPTH = 8;
  localparam int HOLD = 16;
  localparam int SR = 6;
  localparam int SC = 7;

  logic clk_sys = 1'b0;
  logic reset = 1'b1;
  always #5 clk_sys = ~clk_sys;

  kbd_matrix_mapper_if #(.ROWS(ROWS), .COLS(COLS)) bus ();

  kbd_matrix_mapper #(
    .ROWS(ROWS), .COLS(COLS), .FIFO_DEPTH(DEPTH), .HOLD_CYCLES(HOLD),
    .SHIFT_ROW(SR), .SHIFT_COL(SC)
  ) dut (
    .clk_sys(clk_sys),
    .reset(reset),
    .bus(bus)
  );

  // Map ROM {valid, row[2:0], col[2:0], force[1:0]}, one-cycle read.
  logic [8:0] rom [512];
  always @(posedge clk_sys) bus.map_data <= rom[bus.map_addr];

  int checks = 0;
  int errors = 0;
  bit en_cmp = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit [7:0] fn_tab [12] = '{8'h00, 8'h05, 8'h06, 8'h04, 8'h0C, 8'h03, 8'h0B,
                            8'h83, 8'h0A, 8'h01, 8'h09, 8'h78};
  logic [9:0] mq [$];
  logic [9:0] m_cur, m_cap_ev;
  bit  m_inflight, m_cap, m_old, m_fon, m_foff, m_ovf;
  int  m_apply_cnt, m_hold, m_frow, m_fcol;
  bit  m_mat [ROWS][COLS];
  bit [11:1] m_fn;
  bit [2:0]  m_modif;
  bit [8:0]  m_maddr;

  task automatic m_clear();
    mq.delete();
    m_inflight = 0; m_cap = 0; m_old = 0; m_fon = 0; m_foff = 0; m_ovf = 0;
    m_apply_cnt = 0; m_hold = 0; m_frow = 0; m_fcol = 0;
    m_fn = '0; m_modif = '0; m_maddr = '0; m_cur = '0; m_cap_ev = '0;
    for (int r = 0; r < ROWS; r++) for (int c = 0; c < COLS; c++) m_mat[r][c] = 1;
  endtask

  task automatic m_apply(input logic [9:0] e, output bit applied);
    bit pr, v; bit [7:0] code; logic [8:0] ent; int row, col; bit [1:0] f;
    pr = e[9]; code = e[7:0];
    if (!e[8]) begin
      for (int i = 1; i <= 11; i++) if (fn_tab[i] == code) m_fn[i] = pr;
      if (code == 8'h14) m_modif[2] = pr;
      if (code == 8'h11) m_modif[1] = pr;
      if (code == 8'h59) m_modif[0] = pr;
    end
    ent = rom[e[8:0]];
    v = ent[8]; row = int'(ent[7:5]); col = int'(ent[4:2]); f = ent[1:0];
    applied = v && row < ROWS && col < COLS;
    if (applied) begin
      m_mat[row][col] = !pr;
      if (pr && f == 2'b01) begin m_fon = 1; m_foff = 0; m_frow = row; m_fcol = col; end
      else if (pr && f == 2'b10) begin m_fon = 0; m_foff = 1; m_frow = row; m_fcol = col; end
      else if (!pr && row == m_frow && col == m_fcol) begin m_fon = 0; m_foff = 0; end
    end
  endtask

  always @(posedge clk_sys or posedge reset) begin
    if (reset) m_clear();
    else begin
      bit do_pop, was_full, applied;
      do_pop   = !m_inflight && m_hold == 0 && mq.size() > 0;
      was_full = mq.size() == DEPTH;
      if (m_hold > 0) m_hold--;
      else if (m_inflight) begin
        m_apply_cnt--;
        if (m_apply_cnt == 0) begin
          m_apply(m_cur, applied);
          m_inflight = 0;
          if (applied && HOLD > 0) m_hold = HOLD;
        end
      end
      if (do_pop) begin
        m_cur = mq.pop_front();
        m_maddr = m_cur[8:0];
        m_inflight = 1;
        m_apply_cnt = 2;
      end
      if (m_cap) begin
        if (was_full) m_ovf = 1;
        else mq.push_back(m_cap_ev);
      end
      m_cap = (bus.ps2_key[10] != m_old);
      m_cap_ev = bus.ps2_key[9:0];
      m_old = bus.ps2_key[10];
    end
  end

  function automatic logic [ROWS-1:0] exp_rows(input logic [COLS-1:0] a);
    logic [ROWS-1:0] res = '1;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) begin
        bit e = m_mat[r][c];
        if (r == SR && c == SC) begin
          if (m_fon) e = 0;
          else if (m_foff) e = 1;
        end
        if (!a[c] && !e) res[r] = 0;
      end
    return res;
  endfunction

  function automatic int m_pressed();
    int n = 0;
    for (int r = 0; r < ROWS; r++) for (int c = 0; c < COLS; c++) if (!m_mat[r][c]) n++;
    return n;
  endfunction

  function automatic bit m_busy();
    return m_inflight || m_hold > 0 || mq.size() > 0;
  endfunction

  // Per-cycle comparison of every output against the model.
  always @(negedge clk_sys) begin
    if (en_cmp)
      check("cycle",
            {bus.kb_rows, bus.Fn, bus.modif, bus.fifo_ovf, bus.busy, bus.map_addr},
            {exp_rows(bus.addr), m_fn, m_modif, m_ovf, m_busy(), m_maddr});
  end

  // ---------------- stimulus ----------------
  task automatic send(input bit ext, input bit [7:0] code, input bit pr);
    @(posedge clk_sys); #1;
    bus.ps2_key = {~bus.ps2_key[10], pr, ext, code};
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    repeat (3) @(posedge clk_sys);
    #1;
    while (bus.busy && n < 5000) begin
      @(posedge clk_sys); #1;
      n++;
    end
    check({name, "_idle"}, {31'd0, bus.busy}, 32'd0);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk_sys);
    #1;
  endtask

  bit [7:0] rcodes [16] = '{8'h05, 8'h06, 8'h04, 8'h0C, 8'h03, 8'h0B, 8'h83, 8'h0A,
                            8'h01, 8'h09, 8'h78, 8'h14, 8'h11, 8'h59, 8'h1C, 8'h55};

  initial begin
    bus.ps2_key = '0;
    bus.addr = '1;
    for (int i = 0; i < 512; i++) rom[i] = '0;
    tick(1);
    en_cmp = 1;
    tick(2);
    check("rst_rows", 32'(bus.kb_rows), 32'h7F);
    check("rst_status", {bus.Fn, bus.modif, bus.fifo_ovf, bus.busy, bus.map_addr}, 32'd0);
    reset = 1'b0;

    // 1: press A -> r0c1, latency t+4
    rom[{1'b0, 8'h1C}] = {1'b1, 3'd0, 3'd1, 2'b00};
    bus.addr = 8'hFD;
    send(0, 8'h1C, 1);
    tick(4);
    check("t1_before", 32'(bus.kb_rows), 32'h7F);
    tick(1);
    check("t1_press", 32'(bus.kb_rows), 32'h7E);
    wait_idle("t1");
    check("t1_model", 32'(exp_rows(8'hFD)), 32'h7E);
    send(0, 8'h1C, 0);
    wait_idle("t1r");
    check("t1_release", 32'(bus.kb_rows), 32'h7F);

    // 2: '=' -> r5c5 with shift forced on
    rom[{1'b0, 8'h55}] = {1'b1, 3'd5, 3'd5, 2'b01};
    bus.addr = 8'h7F;
    send(0, 8'h55, 1);
    wait_idle("t2");
    check("t2_shift", 32'(bus.kb_rows), 32'h3F);
    check("t2_model", 32'(exp_rows(8'h7F)), 32'h3F);
    bus.addr = 8'hDF; #1;
    check("t2_key", 32'(bus.kb_rows), 32'h5F);
    send(0, 8'h55, 0);
    wait_idle("t2r");
    bus.addr = 8'h5F; #1;
    check("t2_release", 32'(bus.kb_rows), 32'h7F);

    // 3: 12 back-to-back toggles, 9 survive
    for (int i = 0; i < 12; i++) rom[{1'b0, 8'(8'h20 + i)}] = {1'b1, 3'(i / 8), 3'(i % 8), 2'b00};
    for (int i = 0; i < 12; i++) send(0, 8'(8'h20 + i), 1);
    wait_idle("t3");
    check("t3_ovf", {31'd0, bus.fifo_ovf}, 32'd1);
    check("t3_model_count", m_pressed(), 9);
    bus.addr = 8'hFD; #1;
    check("t3_col1", 32'(bus.kb_rows), 32'h7E);
    bus.addr = 8'hFE; #1;
    check("t3_col0", 32'(bus.kb_rows), 32'h7C);
    for (int i = 0; i < 12; i++) begin
      send(0, 8'(8'h20 + i), 0);
      wait_idle("t3r");
    end

    // 4: unmapped F7 and ctrl still drive Fn/modif
    bus.addr = 8'h00;
    send(0, 8'h83, 1);
    send(0, 8'h14, 1);
    wait_idle("t4");
    check("t4_fn", 32'(bus.Fn), 32'h040);
    check("t4_modif", 32'(bus.modif), 32'h4);
    check("t4_rows", 32'(bus.kb_rows), 32'h7F);

    // 6: row out of range -> no matrix change, no HOLD
    rom[{1'b0, 8'h2C}] = {1'b1, 3'd7, 3'd0, 2'b00};
    send(0, 8'h2C, 1);
    tick(4);
    check("t6_busy_apply", {31'd0, bus.busy}, 32'd1);
    tick(1);
    check("t6_busy_done", {31'd0, bus.busy}, 32'd0);
    check("t6_rows", 32'(bus.kb_rows), 32'h7F);

    // 5: async reset during HOLD
    bus.addr = 8'hFD;
    send(0, 8'h1C, 1);
    tick(8);
    check("t5_hold_busy", {31'd0, bus.busy}, 32'd1);
    check("t5_hold_rows", 32'(bus.kb_rows), 32'h7E);
    reset = 1'b1;
    bus.ps2_key = '0;
    bus.addr = 8'h00;
    #1;
    check("t5_rows", 32'(bus.kb_rows), 32'h7F);
    check("t5_status", {bus.Fn, bus.modif, bus.fifo_ovf, bus.busy}, 32'd0);
    tick(2);
    reset = 1'b0;

    // Random traffic
    for (int i = 0; i < 512; i++)
      rom[i] = {($urandom_range(0, 4) != 0), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                2'($urandom_range(0, 3))};
    for (int k = 0; k < 400; k++) begin
      int gap;
      send(($urandom_range(0, 4) == 0), rcodes[$urandom_range(0, 15)], 1'($urandom_range(0, 1)));
      bus.addr = 8'($urandom);
      gap = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 40);
      for (int g = 0; g < gap; g++) begin
        @(posedge clk_sys); #1;
        bus.addr = 8'($urandom);
      end
    end
    wait_idle("rand");
    tick(2);
    en_cmp = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
